// File: rtl/integral_sequencer.sv
// integral_sequencer: run controller that clears, primes, gates and captures a trapezoidal integrator.
module integral_sequencer #(
  parameter int N = 64,
  parameter int CNT_W = 16,
  parameter int FILL_SAMPLES = 2,
  parameter int RES_LAT = 1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             sample_valid,
  input  logic [N-1:0]     integ_result,
  output logic             integ_clear,
  output logic             integ_enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [N-1:0]     result,
  output logic             result_valid,
  output logic [CNT_W-1:0] samples_done
);
  typedef enum logic [2:0] {IDLE, CLEAR, FILL, RUN, DRAIN, DONE} state_t;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_SAMPLES > 0 ? FILL_SAMPLES - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RES_LAT);
  state_t state, next;
  logic [CNT_W-1:0] target, fill_cnt, drain_cnt;
  logic start_req, abort_hit, last_sample, capture;
  always_comb begin
    start_req = state == IDLE && cmd_start && !cmd_abort;
    abort_hit = cmd_abort && state inside {CLEAR, FILL, RUN, DRAIN};
    last_sample = state == RUN && sample_valid && samples_done == target - 1'b1;
    capture = state == DRAIN && drain_cnt == DRAIN_LAST;
    next = state;
    case (state)
      IDLE:    next = start_req && num_samples != '0 ? CLEAR : IDLE;
      CLEAR:   next = FILL_SAMPLES == 0 ? RUN : FILL;
      FILL:    next = sample_valid && fill_cnt == FILL_LAST ? RUN : FILL;
      RUN:     next = last_sample ? DRAIN : RUN;
      DRAIN:   next = capture ? DONE : DRAIN;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (abort_hit) next = IDLE;
  end
  assign integ_clear = state == CLEAR;
  assign integ_enable = state == RUN && sample_valid && !cmd_abort;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign aborted = abort_hit;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      target <= '0;
      fill_cnt <= '0;
      drain_cnt <= '0;
      samples_done <= '0;
      result <= '0;
      result_valid <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (start_req) begin
        cfg_err <= num_samples == '0;
        if (num_samples != '0) begin
          target <= num_samples;
          samples_done <= '0;
          fill_cnt <= '0;
          drain_cnt <= '0;
          result_valid <= 1'b0;
        end
      end
      if (state == FILL && sample_valid && !abort_hit) fill_cnt <= fill_cnt + 1'b1;
      if (integ_enable && samples_done != target) samples_done <= samples_done + 1'b1;
      if (state == DRAIN && !abort_hit) drain_cnt <= drain_cnt + 1'b1;
      if (capture && !abort_hit) begin
        result <= integ_result;
        result_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_integral_sequencer.sv
// tb_integral_sequencer: scoreboard bench with a behavioural accumulator standing in for the integrator.
module tb_integral_sequencer;
  localparam int N = 64;
  localparam int W = 16;
  logic clk = 0, resetb = 0, cmd_start = 0, cmd_abort = 0, sample_valid = 0;
  logic [W-1:0] num_samples = '0;
  logic [N-1:0] acc = '0, sample_data = '0;
  logic integ_clear, integ_enable, busy, done, aborted, cfg_err, result_valid;
  logic [N-1:0] result;
  logic [W-1:0] samples_done;
  int total = 0, bad = 0;
  int en_cnt = 0, clr_cnt = 0, done_cnt = 0, ab_cnt = 0;
  logic [N-1:0] sb[$];

  integral_sequencer dut (
    .clk(clk), .resetb(resetb), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .num_samples(num_samples), .sample_valid(sample_valid), .integ_result(acc),
    .integ_clear(integ_clear), .integ_enable(integ_enable), .busy(busy), .done(done),
    .aborted(aborted), .cfg_err(cfg_err), .result(result), .result_valid(result_valid),
    .samples_done(samples_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    acc <= integ_clear ? '0 : integ_enable ? acc + sample_data : acc;
    en_cnt <= en_cnt + (integ_enable ? 1 : 0);
    clr_cnt <= clr_cnt + (integ_clear ? 1 : 0);
    done_cnt <= done_cnt + (done ? 1 : 0);
    ab_cnt <= ab_cnt + (aborted ? 1 : 0);
  end

  function automatic logic [N-1:0] f(input int k);
    return (64'(k) << 32) + 64'(k * k) + 64'd5;
  endfunction

  function automatic logic [N-1:0] expsum(input int n);
    logic [N-1:0] s = '0;
    for (int k = 2; k < n + 2; k++) s += f(k);
    return s;
  endfunction

  task automatic start(input logic [W-1:0] n);
    @(posedge clk); #1;
    cmd_start = 1; num_samples = n;
    @(posedge clk); #1;
    cmd_start = 0;
    @(negedge clk);
    total++;
    if (integ_clear !== 1'b1) begin bad++; $display("FAIL start_clear: got %b want 1", integ_clear); end
    @(posedge clk); #1;
  endtask

  task automatic feed(input int n, input bit toggle, input int poke, output int first_en);
    int vidx = 0, e0 = en_cnt;
    bit seen = 0, bad_en = 0, busy_drop = 0;
    logic [N-1:0] exp;
    first_en = -1;
    for (int c = 0; c < 100 && !seen; c++) begin
      sample_valid = toggle ? (c % 2 == 0) : 1'b1;
      sample_data = f(vidx);
      cmd_start = c == poke;
      if (c == poke) num_samples = 16'd100;
      @(negedge clk);
      if (integ_enable && !sample_valid) bad_en = 1;
      if (integ_enable && first_en < 0) first_en = c;
      if (!busy) busy_drop = 1;
      if (done) begin
        seen = 1;
        exp = sb.size() > 0 ? sb.pop_front() : 'x;
        total++;
        if (result !== exp) begin bad++; $display("FAIL result: got %0h want %0h", result, exp); end
        total++;
        if (samples_done !== W'(n)) begin bad++; $display("FAIL samples_done: got %0d want %0d", samples_done, n); end
        total++;
        if (result_valid !== 1'b1) begin bad++; $display("FAIL result_valid_done: got %b want 1", result_valid); end
      end
      @(posedge clk); #1;
      cmd_start = 0;
      if (sample_valid) vidx++;
    end
    sample_valid = 0;
    total++;
    if (!seen) begin bad++; $display("FAIL done_timeout: got no done want done within 100 cycles"); end
    total++;
    if (en_cnt - e0 !== n) begin bad++; $display("FAIL enable_count: got %0d want %0d", en_cnt - e0, n); end
    total++;
    if (bad_en || busy_drop) begin bad++; $display("FAIL enable_gating: got bad_en=%b busy_drop=%b want 0 0", bad_en, busy_drop); end
    @(negedge clk);
    total++;
    if ({busy, done, result_valid} !== 3'b001) begin bad++; $display("FAIL after_done: got busy/done/rv=%b want 001", {busy, done, result_valid}); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({integ_clear, integ_enable, busy, done, aborted, cfg_err, result_valid, samples_done, result} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero want all 0");
    end
    @(posedge clk); #1;
    resetb = 1;
  endtask

  task automatic test_basic;
    int c0 = clr_cnt, fe;
    sb.push_back(expsum(4));
    start(4);
    feed(4, 0, -1, fe);
    total++;
    if (fe !== 2) begin bad++; $display("FAIL fill_cycles: got first enable %0d want 2", fe); end
    total++;
    if (clr_cnt - c0 !== 1) begin bad++; $display("FAIL clear_count: got %0d want 1", clr_cnt - c0); end
  endtask

  task automatic test_toggle;
    int d0 = done_cnt, fe;
    sb.push_back(expsum(3));
    start(3);
    total++;
    if (result_valid !== 1'b0) begin bad++; $display("FAIL rv_cleared: got %b want 0", result_valid); end
    feed(3, 1, -1, fe);
    total++;
    if (fe !== 4) begin bad++; $display("FAIL toggle_first_en: got %0d want 4", fe); end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL done_once: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_cfg_err;
    int c0 = clr_cnt, fe;
    @(posedge clk); #1;
    cmd_start = 1; num_samples = 0;
    @(posedge clk); #1;
    cmd_start = 0;
    @(negedge clk);
    total++;
    if ({cfg_err, busy, result_valid} !== 3'b101) begin bad++; $display("FAIL cfg_err_set: got err/busy/rv=%b want 101", {cfg_err, busy, result_valid}); end
    total++;
    if (clr_cnt !== c0) begin bad++; $display("FAIL cfg_err_clear: got %0d clears want 0", clr_cnt - c0); end
    sb.push_back(expsum(2));
    start(2);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_cleared: got %b want 0", cfg_err); end
    feed(2, 0, -1, fe);
  endtask

  task automatic test_abort;
    int k = 0, vidx = 0, a0 = ab_cnt;
    start(10);
    for (int c = 0; c < 50 && k < 5; c++) begin
      sample_valid = 1; sample_data = f(vidx);
      @(negedge clk);
      if (integ_enable) k++;
      @(posedge clk); #1;
      vidx++;
    end
    cmd_abort = 1;
    @(negedge clk);
    total++;
    if ({integ_enable, aborted} !== 2'b01) begin bad++; $display("FAIL abort_cycle: got en/ab=%b want 01", {integ_enable, aborted}); end
    @(posedge clk); #1;
    cmd_abort = 0; sample_valid = 0;
    @(negedge clk);
    total++;
    if ({busy, aborted, result_valid} !== 3'b000) begin bad++; $display("FAIL after_abort: got busy/ab/rv=%b want 000", {busy, aborted, result_valid}); end
    total++;
    if (samples_done !== 16'd5) begin bad++; $display("FAIL abort_partial: got %0d want 5", samples_done); end
    total++;
    if (ab_cnt - a0 !== 1) begin bad++; $display("FAIL abort_count: got %0d want 1", ab_cnt - a0); end
  endtask

  task automatic test_back_to_back;
    int c0, fe;
    sb.push_back(expsum(6));
    start(6);
    feed(6, 0, 5, fe);
    c0 = clr_cnt;
    @(posedge clk); #1;
    cmd_start = 1; cmd_abort = 1; num_samples = 3;
    @(posedge clk); #1;
    cmd_start = 0; cmd_abort = 0;
    @(negedge clk);
    total++;
    if ({busy, aborted, clr_cnt - c0} !== 34'b0) begin bad++; $display("FAIL start_abort_idle: got busy=%b ab=%b clears=%0d want 0 0 0", busy, aborted, clr_cnt - c0); end
  endtask

  task automatic test_reset_mid_run;
    int d0, a0, fe;
    start(6);
    for (int c = 0; c < 4; c++) begin
      sample_valid = 1; sample_data = f(c);
      @(posedge clk); #1;
    end
    d0 = done_cnt; a0 = ab_cnt;
    resetb = 0;
    #1;
    total++;
    if ({integ_clear, integ_enable, busy, done, aborted, cfg_err, result_valid, samples_done, result} !== '0) begin
      bad++; $display("FAIL reset_mid_run: got busy=%b sd=%0d rv=%b want all 0", busy, samples_done, result_valid);
    end
    sample_valid = 0;
    @(posedge clk); #1;
    resetb = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== d0 || ab_cnt !== a0) begin bad++; $display("FAIL reset_pulses: got done=%0d ab=%0d want 0 0", done_cnt - d0, ab_cnt - a0); end
    sb.push_back(expsum(2));
    start(2);
    feed(2, 0, -1, fe);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_toggle;
    test_cfg_err;
    test_abort;
    test_back_to_back;
    test_reset_mid_run;
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/integral_sequencer.md
Name: integral_sequencer

Overview:
- Run controller for the trapezoidal numerical integrator in the stage-sim measurement chain.
- Accepts a start command and a sample count, then clears the integrator and primes its two-deep sample pipeline.
- Gates the integrator's start_integration enable for exactly the requested number of samples, then captures the accumulated integral into a holding register with a done pulse.
- Sits between the host/command logic and the integrator instance.

Parameters:
N, 64, data width of integrator result and captured result
CNT_W, 16, width of sample-count configuration and counters
FILL_SAMPLES, 2, valid samples consumed to prime integrator pipeline before enabling accumulation
RES_LAT, 1, cycles from last enabled sample until integ_result is stable

Ports:
clk  input  1  system clock
resetb  input  1  asynchronous active-low reset
cmd_start  input  1  single-cycle run request
cmd_abort  input  1  single-cycle abort request
num_samples  input  CNT_W  samples to integrate; sampled on accepted cmd_start
sample_valid  input  1  a new signal_input sample is presented to the integrator this cycle
integ_result  input  N  integral_result from the integrator
integ_clear  output  1  one-cycle clear pulse to integrator accumulator
integ_enable  output  1  drives integrator start_integration
busy  output  1  run in progress (any state except IDLE)
done  output  1  one-cycle pulse when result captured
aborted  output  1  one-cycle pulse when a run is aborted
cfg_err  output  1  sticky: last start request had num_samples==0
result  output  N  captured integral
result_valid  output  1  result holds a completed run's integral
samples_done  output  CNT_W  samples integrated in current/last run

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on resetb. All outputs are 0 in reset, and the state is IDLE.
- FSM states: IDLE, CLEAR, FILL, RUN, DRAIN, DONE.
- IDLE:
  - cmd_start with num_samples!=0: latch target=num_samples, clear samples_done, fill counter and drain counter, clear result_valid and cfg_err, then go to CLEAR.
  - cmd_start with num_samples==0: set cfg_err and stay in IDLE. result and result_valid are unchanged.
- CLEAR: integ_clear=1 for exactly this cycle, then go to FILL.
- FILL:
  - integ_enable=0.
  - Count cycles with sample_valid=1.
  - On the FILL_SAMPLES-th valid sample, go to RUN.
  - FILL_SAMPLES==0: CLEAR goes directly to RUN.
- RUN:
  - integ_enable = sample_valid (combinational, same cycle).
  - Each valid sample increments samples_done.
  - When the valid sample makes samples_done==target, go to DRAIN in the next cycle.
  - Cycles without sample_valid do not count and do not enable.
- DRAIN:
  - integ_enable=0.
  - Wait RES_LAT cycles, then register integ_result into result and go to DONE.
  - RES_LAT==0: capture on the first DRAIN cycle.
- DONE: done=1 and result_valid=1 for one cycle, then go to IDLE. result_valid stays 1 until the next accepted start.
- busy=1 in every state except IDLE.
- Abort:
  - cmd_abort in CLEAR, FILL, RUN or DRAIN: next state is IDLE, integ_enable forced to 0 in that cycle, aborted=1 for one cycle.
  - After an abort, result_valid stays 0 and samples_done holds its partial count.
  - cmd_abort in IDLE or DONE is ignored. DONE completes normally.
- Simultaneous events:
  - cmd_start while busy is ignored and does not relatch num_samples.
  - cmd_start and cmd_abort together in IDLE: both are ignored.
  - cmd_abort in the same cycle as the final RUN sample: abort wins, and the sample is not enabled.
- Counters: samples_done saturates at target and never wraps. The maximum run is 2^CNT_W-1 samples.
- Reset mid-run: all state returns to reset values immediately. No done or aborted pulse is produced.
- The integrator's own arithmetic and scaling are outside this block. result is a bit-exact copy of integ_result.

Test Plan:
- Reset, then start with num_samples=4, sample_valid held 1 -> integ_clear pulse 1 cycle after start; FILL 2 cycles; integ_enable high exactly 4 cycles; done 1 cycle after DRAIN; samples_done=4; result equals integ_result model.
- Start num_samples=3, sample_valid toggling 1,0,1,0... -> integ_enable asserted only on valid cycles, exactly 3 times; busy stays high throughout; done once.
- Start num_samples=0 -> cfg_err=1, busy stays 0, no integ_clear. A later start num_samples=2 clears cfg_err and completes.
- Start num_samples=10, abort after 5 enabled samples -> aborted pulse, integ_enable low from the abort cycle, samples_done=5, result_valid=0, busy=0 next cycle.
- cmd_start again during RUN with num_samples=100 -> ignored; run finishes at the original count of 6. Start and abort together in IDLE -> no activity.
- resetb low during RUN for 1 cycle -> all outputs 0 immediately, state IDLE, no done or aborted pulse. A subsequent run of 2 samples completes normally.
